// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer: exception/interrupt/MRET arbitration, redirect, flush and drain.
// Optional trap counter enabled by the TRAP_COUNT_EN macro.
module trap_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exc_valid,
  input  logic [31:0]      exc_pc,
  input  logic [4:0]       exc_cause,
  input  logic             irq_pending,
  input  logic             irq_enable,
  input  logic             mret_valid,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc_cur,
  output logic             req_ready,
  output logic             exception_asserted,
  output logic [31:0]      exception_mepc,
  output logic [31:0]      exception_mcause,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, DRAIN} state_e;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [31:0] IRQ_MCAUSE = 32'h8000_000B;
  localparam logic [31:0] IRQ_VEC_OFS = 32'd44;

  state_e        state_q, state_d;
  logic          is_irq_q, is_irq_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          exc_asserted_q, exc_asserted_d;
  logic [31:0]   mepc_q, mepc_d;
  logic [31:0]   mcause_q, mcause_d;
  logic          redir_valid_q, redir_valid_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic          stall_q, stall_d;

  always_comb begin
    state_d        = state_q;
    is_irq_d       = is_irq_q;
    drain_cnt_d    = drain_cnt_q;
    exc_asserted_d = 1'b0;
    redir_valid_d  = 1'b0;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    redir_pc_d     = redir_pc_q;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          state_d        = COMMIT;
          is_irq_d       = 1'b0;
          exc_asserted_d = 1'b1;
          mepc_d         = {exc_pc[31:2], 2'b00};
          mcause_d       = {27'b0, exc_cause};
        end else if (irq_pending && irq_enable) begin
          // exc_pc carries the next-PC while no exception is being reported
          state_d        = COMMIT;
          is_irq_d       = 1'b1;
          exc_asserted_d = 1'b1;
          mepc_d         = {exc_pc[31:2], 2'b00};
          mcause_d       = IRQ_MCAUSE;
        end else if (mret_valid) begin
          state_d       = REDIRECT;
          is_irq_d      = 1'b0;
          redir_valid_d = 1'b1;
          redir_pc_d    = {mepc_cur[31:2], 2'b00};
        end
      end
      COMMIT: begin
        // mtvec sampled here so a CSR write racing the trap request is honoured
        state_d       = REDIRECT;
        redir_valid_d = 1'b1;
        redir_pc_d    = {mtvec[31:2], 2'b00};
        if (is_irq_q && (mtvec[1:0] == 2'b01)) begin
          redir_pc_d = {mtvec[31:2], 2'b00} + IRQ_VEC_OFS;
        end
      end
      REDIRECT: begin
        if (DRAIN_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d     = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      is_irq_q       <= 1'b0;
      drain_cnt_q    <= '0;
      req_ready_q    <= 1'b1;
      exc_asserted_q <= 1'b0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= '0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_irq_q       <= is_irq_d;
      drain_cnt_q    <= drain_cnt_d;
      req_ready_q    <= req_ready_d;
      exc_asserted_q <= exc_asserted_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      redir_valid_q  <= redir_valid_d;
      redir_pc_q     <= redir_pc_d;
      stall_q        <= stall_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign exception_asserted = exc_asserted_q;
  assign exception_mepc     = mepc_q;
  assign exception_mcause   = mcause_q;
  assign redirect_valid     = redir_valid_q;
  assign flush              = redir_valid_q;
  assign redirect_pc        = redir_pc_q;
  assign stall              = stall_q;

`ifdef TRAP_COUNT_EN
  logic [CNT_W-1:0] trap_count_q, trap_count_d;

  always_comb begin
    trap_count_d = trap_count_q + CNT_W'(exc_asserted_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trap_count_q <= '0;
    end else begin
      trap_count_q <= trap_count_d;
    end
  end

  assign trap_count = trap_count_q;
`else
  assign trap_count = '0;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl.
module tb_trap_ctrl;
  localparam int DRAIN = 2;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             exc_valid, irq_pending, irq_enable, mret_valid;
  logic [31:0]      exc_pc, mtvec, mepc_cur;
  logic [4:0]       exc_cause;
  logic             req_ready, exception_asserted, redirect_valid, flush, stall;
  logic [31:0]      exception_mepc, exception_mcause, redirect_pc;
  logic [CNT_W-1:0] trap_count;

  trap_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_cause(exc_cause),
    .irq_pending(irq_pending), .irq_enable(irq_enable), .mret_valid(mret_valid),
    .mtvec(mtvec), .mepc_cur(mepc_cur),
    .req_ready(req_ready), .exception_asserted(exception_asserted),
    .exception_mepc(exception_mepc), .exception_mcause(exception_mcause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .stall(stall), .trap_count(trap_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int traps_model = 0;

  typedef struct {
    logic [31:0] mepc;
    logic [31:0] mcause;
  } trap_t;

  trap_t       trap_q[$];
  logic [31:0] redir_q[$];
  trap_t       mon_t;
  logic [31:0] mon_pc;
  logic        prev_ea = 1'b0;
  logic        prev_rv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef TRAP_COUNT_EN
    return 32'(traps_model % (1 << CNT_W));
`else
    return 32'd0;
`endif
  endfunction

  // Scoreboard monitor: pops an expectation whenever the DUT pulses an output.
  always @(negedge clock) begin
    if (reset) begin
      prev_ea = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (exception_asserted) begin
        if (trap_q.size() == 0) begin
          check("unexpected_trap", 32'(exception_asserted), 32'd0);
        end else begin
          mon_t = trap_q.pop_front();
          check("mepc", exception_mepc, mon_t.mepc);
          check("mcause", exception_mcause, mon_t.mcause);
        end
        if (prev_ea) check("ea_single_pulse", 32'(exception_asserted), 32'd0);
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redirect", 32'(redirect_valid), 32'd0);
        end else begin
          mon_pc = redir_q.pop_front();
          check("redirect_pc", redirect_pc, mon_pc);
        end
        if (prev_rv) check("rv_single_pulse", 32'(redirect_valid), 32'd0);
      end
      if (flush !== redirect_valid) check("flush_eq_redirect", 32'(flush), 32'(redirect_valid));
      if (req_ready !== !stall) check("ready_eq_not_stall", 32'(req_ready), 32'(!stall));
      prev_ea = exception_asserted;
      prev_rv = redirect_valid;
    end
  end

  task automatic clr_req();
    exc_valid   = 1'b0;
    irq_pending = 1'b0;
    mret_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) break;
    end
    check(tag, 32'(req_ready), 32'd1);
  endtask

  task automatic push_trap(input logic [31:0] mepc, input logic [31:0] mcause, input logic [31:0] pc);
    trap_t t;
    t.mepc   = mepc;
    t.mcause = mcause;
    trap_q.push_back(t);
    redir_q.push_back(pc);
    traps_model++;
  endtask

  initial begin
    reset      = 1'b1;
    clr_req();
    irq_enable = 1'b0;
    exc_pc     = '0;
    exc_cause  = '0;
    mtvec      = '0;
    mepc_cur   = '0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ea", 32'(exception_asserted), 32'd0);
    check("rst_redirect", 32'(redirect_valid), 32'd0);
    check("rst_mepc", exception_mepc, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_trap_count", 32'(trap_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Illegal instruction, direct mode
    exc_valid = 1'b1; exc_pc = 32'h0000_0104; exc_cause = 5'd2; mtvec = 32'h0000_0200;
    push_trap(32'h104, 32'h2, 32'h200);
    @(negedge clock);                                  // N+1
    clr_req();
    check("t1_ea_n1", 32'(exception_asserted), 32'd1);
    check("t1_stall_n1", 32'(stall), 32'd1);
    @(negedge clock);                                  // N+2
    check("t1_redirect_n2", 32'(redirect_valid), 32'd1);
    check("t1_flush_n2", 32'(flush), 32'd1);
    check("t1_mepc_hold", exception_mepc, 32'h104);
    @(negedge clock);                                  // N+3
    check("t1_stall_n3", 32'(stall), 32'd1);
    @(negedge clock);                                  // N+4
    check("t1_stall_n4", 32'(stall), 32'd1);
    check("t1_ready_n4", 32'(req_ready), 32'd0);
    @(negedge clock);                                  // N+5
    check("t1_ready_n5", 32'(req_ready), 32'd1);
    check("t1_count", 32'(trap_count), exp_count());

    // Vectored interrupt
    irq_pending = 1'b1; irq_enable = 1'b1; exc_pc = 32'h0000_0300; mtvec = 32'h0000_1001;
    push_trap(32'h300, 32'h8000_000B, 32'h102C);
    @(negedge clock);
    clr_req();
    check("t2_ea", 32'(exception_asserted), 32'd1);
    wait_idle("t2_idle");

    // Interrupt masked: no response
    irq_pending = 1'b1; irq_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t2_masked_ready", 32'(req_ready), 32'd1);
    end
    clr_req();

    // Simultaneous: exception wins, held interrupt follows after drain
    exc_valid = 1'b1; irq_pending = 1'b1; irq_enable = 1'b1; mret_valid = 1'b1;
    exc_cause = 5'd11; exc_pc = 32'h0000_0400; mtvec = 32'h0000_1001;
    push_trap(32'h400, 32'hB, 32'h1000);
    @(negedge clock);                                  // N+1
    exc_valid = 1'b0; mret_valid = 1'b0; exc_pc = 32'h0000_0500;
    push_trap(32'h500, 32'h8000_000B, 32'h102C);
    check("t3_ea", 32'(exception_asserted), 32'd1);
    repeat (4) @(negedge clock);                       // N+5
    check("t3_ready_n5", 32'(req_ready), 32'd1);
    check("t3_no_ea_n5", 32'(exception_asserted), 32'd0);
    @(negedge clock);                                  // N+6: irq taken
    irq_pending = 1'b0;
    check("t3_irq_ea", 32'(exception_asserted), 32'd1);
    wait_idle("t3_idle");

    // MRET
    mepc_cur = 32'h0000_0107; mret_valid = 1'b1;
    redir_q.push_back(32'h104);
    @(negedge clock);                                  // N+1
    clr_req();
    check("t4_redirect_n1", 32'(redirect_valid), 32'd1);
    check("t4_no_ea", 32'(exception_asserted), 32'd0);
    @(negedge clock);
    @(negedge clock);                                  // N+3
    check("t4_ready_n3", 32'(req_ready), 32'd0);
    @(negedge clock);                                  // N+4
    check("t4_ready_n4", 32'(req_ready), 32'd1);
    check("t4_count", 32'(trap_count), exp_count());

    // Reset during REDIRECT
    exc_valid = 1'b1; exc_pc = 32'h0000_0600; exc_cause = 5'd4; mtvec = 32'h0000_0800;
    push_trap(32'h600, 32'h4, 32'h800);
    @(negedge clock);
    clr_req();
    @(negedge clock);                                  // REDIRECT
    check("t5_in_redirect", 32'(redirect_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    traps_model = 0;
    check("t5_rst_redirect", 32'(redirect_valid), 32'd0);
    check("t5_rst_flush", 32'(flush), 32'd0);
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    check("t5_rst_mepc", exception_mepc, 32'd0);
    check("t5_rst_pc", redirect_pc, 32'd0);
    check("t5_rst_count", 32'(trap_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("t5_ready_after", 32'(req_ready), 32'd1);

    // Trap counter wrap over 17 traps
    mtvec = 32'h0000_0200;
    for (int k = 0; k < 17; k++) begin
      exc_valid = 1'b1; exc_pc = 32'h1000 + 32'(k * 4); exc_cause = 5'(k);
      push_trap(32'h1000 + 32'(k * 4), 32'(k), 32'h200);
      @(negedge clock);
      clr_req();
      wait_idle("t6_idle");
      check("t6_count", 32'(trap_count), exp_count());
    end

    repeat (3) @(negedge clock);
    check("trap_q_empty", 32'(trap_q.size()), 32'd0);
    check("redir_q_empty", 32'(redir_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
